// File: rtl/ide_sector_fifo.sv
// Sector-buffer FIFO for the IDE data path: registered head word, exact fill level, sector counters, sticky errors.
// Level/full update on the accepting edge; a write into an empty FIFO is readable one edge later; blocked ops set sticky flags.
module ide_sector_fifo #(
   parameter int DW = 16,
   parameter int AW = 12,
   parameter int SW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clk7_en,
   input  logic          flush,
   input  logic [DW-1:0] data_in,
   input  logic          wr,
   input  logic          rd,
   output logic [DW-1:0] data_out,
   output logic [AW:0]   level,
   output logic [AW-SW:0] sectors,
   output logic          sector_rdy,
   output logic          sector_room,
   output logic          full,
   output logic          empty,
   output logic          last,
   output logic          overflow,
   output logic          underflow
);

   localparam logic [AW:0] ONE   = 1;
   localparam logic [AW:0] DEPTH = ONE << AW;
   localparam logic [AW:0] SECT  = ONE << SW;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW:0]   inptr;
   logic [AW:0]   outptr;
   logic [AW:0]   inptr_next;
   logic [AW:0]   outptr_next;
   logic          empty_dly;
   logic          wr_ok;
   logic          rd_ok;
   logic [AW-1:0] rd_addr;
   logic          bypass;

   assign level       = inptr - outptr;
   assign full        = (level == DEPTH);
   assign empty       = (level == '0) | empty_dly;
   assign sectors     = level[AW:SW];
   assign sector_rdy  = (level >= SECT);
   assign sector_room = (level <= DEPTH - SECT);
   assign last        = &outptr[SW-1:0];

   assign wr_ok       = wr & ~full;
   assign rd_ok       = rd & ~empty;
   assign inptr_next  = inptr + {{AW{1'b0}}, wr_ok};
   assign outptr_next = outptr + {{AW{1'b0}}, rd_ok};

   // Head word may be the one being written this edge; forward it so data_out never goes stale.
   assign rd_addr = flush ? '0 : outptr_next[AW-1:0];
   assign bypass  = ~flush & wr_ok & (inptr[AW-1:0] == rd_addr);

   always_ff @(posedge clk) begin
      if (clk7_en && reset_n && !flush && wr_ok)
         mem[inptr[AW-1:0]] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (clk7_en) begin
         if (!reset_n)
            data_out <= '0;
         else if (bypass)
            data_out <= data_in;
         else
            data_out <= mem[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (clk7_en) begin
         if (!reset_n || flush) begin
            inptr     <= '0;
            outptr    <= '0;
            empty_dly <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            inptr     <= inptr_next;
            outptr    <= outptr_next;
            empty_dly <= (level == '0);
            overflow  <= overflow | (wr & full);
            underflow <= underflow | (rd & empty);
         end
      end
   end

endmodule
